// File: rtl/spi_flash_reader_pkg.sv
// spi_flash_reader_pkg: register map, flash opcodes, FSM states and header byte selection
package spi_flash_reader_pkg;
  localparam logic [1:0] REG_DATA  = 2'd0;
  localparam logic [1:0] REG_CS    = 2'd1;
  localparam logic [1:0] REG_READY = 2'd2;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] DUMMY     = 8'h00;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CSON  = 3'd1;
  localparam state_t S_HDR   = 3'd2;
  localparam state_t S_RXTX  = 3'd3;
  localparam state_t S_OUT   = 3'd4;
  localparam state_t S_CSOFF = 3'd5;
  localparam state_t S_DONE  = 3'd6;
  function automatic logic [7:0] hdr_byte(input logic [1:0] n, input logic [23:0] a);
    return n == 2'd0 ? CMD_READ : n == 2'd1 ? a[23:16] : n == 2'd2 ? a[15:8] : a[7:0];
  endfunction
endpackage

// File: rtl/spi_flash_reader_wb8_access.sv
// wb8_access: single-access 8-bit Wishbone master with a one-cycle strobe
module wb8_access (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       we,
  input  logic [1:0] adr,
  input  logic [7:0] dat,
  output logic       done,
  output logic [7:0] rdata,
  output logic       wb_stb,
  output logic       wb_we,
  output logic [1:0] wb_adr,
  output logic [7:0] wb_dat,
  input  logic       wb_ack,
  input  logic [7:0] wb_rdat
);
  logic pend;
  assign done = pend && wb_ack;
  always_ff @(posedge clk)
    if (rst) begin
      pend   <= 1'b0;
      wb_stb <= 1'b0;
      wb_we  <= 1'b0;
      wb_adr <= '0;
      wb_dat <= '0;
      rdata  <= '0;
    end else begin
      wb_stb <= req;
      pend   <= req || (pend && !wb_ack);
      if (req) begin
        wb_we  <= we;
        wb_adr <= adr;
        wb_dat <= dat;
      end
      if (done) rdata <= wb_rdat;
    end
endmodule

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: sequences SPI-flash READ transactions through the Wishbone SPI peripheral
module spi_flash_reader
  import spi_flash_reader_pkg::*;
(
  input  logic        I_wb_clk,
  input  logic        I_reset,
  input  logic        I_start,
  input  logic [23:0] I_addr,
  input  logic [15:0] I_len,
  output logic        O_busy,
  output logic        O_done,
  output logic [7:0]  O_data,
  output logic        O_valid,
  input  logic        I_ready,
  output logic        O_wb_stb,
  output logic        O_wb_we,
  output logic [1:0]  O_wb_adr,
  output logic [7:0]  O_wb_dat,
  input  logic [7:0]  I_wb_dat,
  input  logic        I_wb_ack
);
  state_t state, ns;
  logic [1:0] hcnt, nh, step, nst;
  logic pol, np, req, r_we, done, rdy;
  logic [1:0] r_adr;
  logic [7:0] r_dat;
  logic [15:0] cnt, nc;
  logic [23:0] addr_q, na;
  assign rdy     = I_wb_dat[0];
  assign O_busy  = state != S_IDLE && state != S_DONE;
  assign O_done  = state == S_DONE;
  assign O_valid = state == S_OUT;
  // The next access is requested in the ack cycle of the current one so the strobe lands right after the ack.
  always_comb begin
    ns = state;
    nh = hcnt;
    np = pol;
    nst = step;
    nc = cnt;
    na = addr_q;
    req = 1'b0;
    r_adr = REG_READY;
    r_we = 1'b0;
    r_dat = DUMMY;
    case (state)
      S_IDLE: if (I_start) begin
        ns = I_len == 16'd0 ? S_DONE : S_CSON;
        nc = I_len;
        na = I_addr;
        req = I_len != 16'd0;
        r_adr = REG_CS;
        r_we = 1'b1;
        r_dat = 8'h01;
      end
      S_CSON: if (done) begin
        ns = S_HDR;
        nh = 2'd0;
        np = 1'b1;
        req = 1'b1;
      end
      S_HDR: if (done) begin
        req = 1'b1;
        np = pol ? !rdy : 1'b1;
        r_adr = pol && rdy ? REG_DATA : REG_READY;
        r_we = pol && rdy;
        r_dat = hdr_byte(hcnt, addr_q);
        if (!pol) begin
          nh = hcnt + 2'd1;
          ns = hcnt == 2'd3 ? S_RXTX : S_HDR;
          nst = 2'd0;
        end
      end
      S_RXTX: if (done) begin
        req = step != 2'd3;
        r_adr = !step[0] && rdy ? REG_DATA : REG_READY;
        r_we = step == 2'd0 && rdy;
        nst = step[0] || rdy ? step + 2'd1 : step;
        ns = step == 2'd3 ? S_OUT : S_RXTX;
      end
      S_OUT: if (I_ready) begin
        nc = cnt - 16'd1;
        req = 1'b1;
        ns = cnt == 16'd1 ? S_CSOFF : S_RXTX;
        nst = 2'd0;
        r_adr = cnt == 16'd1 ? REG_CS : REG_READY;
        r_we = cnt == 16'd1;
      end
      S_CSOFF: if (done) ns = S_DONE;
      default: ns = S_IDLE;
    endcase
  end
  always_ff @(posedge I_wb_clk)
    if (I_reset) begin
      state  <= S_IDLE;
      hcnt   <= '0;
      pol    <= 1'b0;
      step   <= '0;
      cnt    <= '0;
      addr_q <= '0;
    end else begin
      state  <= ns;
      hcnt   <= nh;
      pol    <= np;
      step   <= nst;
      cnt    <= nc;
      addr_q <= na;
    end
  wb8_access u_wb (
    .clk(I_wb_clk),
    .rst(I_reset),
    .req(req),
    .we(r_we),
    .adr(r_adr),
    .dat(r_dat),
    .done(done),
    .rdata(O_data),
    .wb_stb(O_wb_stb),
    .wb_we(O_wb_we),
    .wb_adr(O_wb_adr),
    .wb_dat(O_wb_dat),
    .wb_ack(I_wb_ack),
    .wb_rdat(I_wb_dat)
  );
endmodule
